uart_program_loader: RTL

Boot-time controller that owns the instruction memory write port. It receives a framed byte stream from the UART receiver, assembles little-endian 32-bit words, and writes them to consecutive program-memory addresses. While loading, it holds the CPU core in reset and steers the program-memory address away from the fetch stage. When the frame completes, it hands the memory back to the fetch stage and releases the core.

---
 rtl/uart_program_loader.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/uart_program_loader.sv
// Boot loader: assembles little-endian words from a framed UART byte stream and
// writes them to program memory while holding the core in reset.
module uart_program_loader #(
  parameter int         MEM_WORDS      = 1024,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] MAGIC          = 8'hA5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  input  logic [31:0] i_pc_address,
  output logic [31:0] o_mem_address,
  output logic        o_mem_write_enable,
  output logic [31:0] o_mem_write_data,
  output logic        o_cpu_reset_n,
  output logic        o_loading,
  output logic        o_load_error,
  output logic [15:0] o_words_loaded
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_RELEASE,
    S_ERROR
  } state_t;

  state_t        r_state;
  logic [7:0]    r_len_lo;
  logic [15:0]   r_count;
  logic [15:0]   r_word_idx;
  logic [1:0]    r_byte_idx;
  logic [23:0]   r_held;
  logic [31:0]   r_waddr;
  logic [31:0]   r_wdata;
  logic          r_we;
  logic          r_load_error;
  logic [15:0]   r_words_loaded;
  logic [TW-1:0] r_timer;

  logic [15:0] w_count;
  logic        w_magic;
  logic        w_timing;
  logic        w_timeout;
  logic        w_last;
  logic        w_bad_len;

  assign w_count   = {i_rx_data, r_len_lo};
  assign w_magic   = i_rx_valid && (i_rx_data == MAGIC);
  assign w_timing  = (r_state == S_LEN0) || (r_state == S_LEN1) || (r_state == S_DATA);
  // An arriving byte always beats an expiring timer.
  assign w_timeout = w_timing && !i_rx_valid && (r_timer == TW'(TIMEOUT_CYCLES - 1));
  assign w_last    = (r_word_idx == r_count - 16'd1);
  assign w_bad_len = (w_count == 16'd0) || (int'(w_count) > MEM_WORDS);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_len_lo       <= '0;
      r_count        <= '0;
      r_word_idx     <= '0;
      r_byte_idx     <= '0;
      r_held         <= '0;
      r_waddr        <= '0;
      r_wdata        <= '0;
      r_we           <= 1'b0;
      r_load_error   <= 1'b0;
      r_words_loaded <= '0;
      r_timer        <= '0;
    end else begin
      r_we <= 1'b0;
      if (r_we) begin
        r_word_idx     <= r_word_idx + 16'd1;
        r_words_loaded <= r_words_loaded + 16'd1;
      end

      if (!w_timing || i_rx_valid) r_timer <= '0;
      else                         r_timer <= r_timer + TW'(1);

      if (w_timeout) begin
        r_state      <= S_ERROR;
        r_load_error <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE, S_ERROR: begin
            if (w_magic) begin
              r_state        <= S_LEN0;
              r_load_error   <= 1'b0;
              r_words_loaded <= '0;
              r_waddr        <= '0;
            end
          end
          S_LEN0: begin
            if (i_rx_valid) begin
              r_len_lo <= i_rx_data;
              r_state  <= S_LEN1;
            end
          end
          S_LEN1: begin
            if (i_rx_valid) begin
              r_count <= w_count;
              if (w_bad_len) begin
                r_state      <= S_ERROR;
                r_load_error <= 1'b1;
              end else begin
                r_state    <= S_DATA;
                r_byte_idx <= '0;
                r_word_idx <= '0;
              end
            end
          end
          S_DATA: begin
            if (i_rx_valid) begin
              r_byte_idx <= r_byte_idx + 2'd1;
              case (r_byte_idx)
                2'd0: r_held[7:0]   <= i_rx_data;
                2'd1: r_held[15:8]  <= i_rx_data;
                2'd2: r_held[23:16] <= i_rx_data;
                default: begin
                  r_wdata <= {i_rx_data, r_held};
                  r_waddr <= {14'd0, r_word_idx, 2'b00};
                  r_we    <= 1'b1;
                  if (w_last) r_state <= S_RELEASE;
                end
              endcase
            end
          end
          S_RELEASE: r_state <= S_IDLE;
          default:   r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_loading          = (r_state != S_IDLE);
  assign o_cpu_reset_n      = (r_state == S_IDLE);
  assign o_mem_address      = o_loading ? r_waddr : i_pc_address;
  assign o_mem_write_enable = r_we;
  assign o_mem_write_data   = r_wdata;
  assign o_load_error       = r_load_error;
  assign o_words_loaded     = r_words_loaded;

endmodule
